// File: rtl/vga_tmds_enc_pkg.sv
// Shared constants and helpers for the VGA-to-TMDS encoder.
//   - TMDS control tokens for each C1C0 combination
//   - default 640x480@60 active-window timing
//   - RGB444 pixel layout and 4-to-8-bit colour expansion
package vga_tmds_enc_pkg;

    localparam logic [9:0] TOK_C00 = 10'h354;
    localparam logic [9:0] TOK_C01 = 10'h0AB;
    localparam logic [9:0] TOK_C10 = 10'h154;
    localparam logic [9:0] TOK_C11 = 10'h2AB;

    localparam int unsigned H_START_DEF = 144;
    localparam int unsigned H_ACT_DEF   = 640;
    localparam int unsigned V_START_DEF = 35;
    localparam int unsigned V_ACT_DEF   = 480;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Replicating the nibble maps 0 -> 00 and F -> FF exactly.
    function automatic logic [7:0] expand4(input logic [3:0] nib);
        return {nib, nib};
    endfunction

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] tok;
        case (c)
            2'b00:   tok = TOK_C00;
            2'b01:   tok = TOK_C01;
            2'b10:   tok = TOK_C10;
            default: tok = TOK_C11;
        endcase
        return tok;
    endfunction

endpackage

// File: rtl/tmds_enc_ch.sv
// One TMDS channel: transition-minimising stage (S1) followed by the
// DC-balancing stage (S2) which owns the running disparity.
// Ports:
//   i_clk    pixel clock
//   i_rst_n  synchronous active-low reset
//   i_data   8-bit colour value (from S0)
//   i_de     data enable (from S0)
//   i_ctrl   C1C0 control bits sent while i_de=0
//   o_sym    10-bit TMDS symbol, two clocks after the inputs
module tmds_enc_ch
    import vga_tmds_enc_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic       i_de,
    input  logic [1:0] i_ctrl,
    output logic [9:0] o_sym
);

    // ---------------- S1: q_m ----------------
    logic [3:0] w_d_ones;
    logic       w_use_xnor;
    logic [8:0] w_qm;

    always_comb begin
        logic v_bit;
        w_d_ones   = 4'($countones(i_data));
        w_use_xnor = (w_d_ones > 4'd4) || ((w_d_ones == 4'd4) && !i_data[0]);
        w_qm       = '0;
        v_bit      = i_data[0];
        w_qm[0]    = v_bit;
        for (int i = 1; i < 8; i++) begin
            v_bit   = w_use_xnor ? ~(v_bit ^ i_data[i]) : (v_bit ^ i_data[i]);
            w_qm[i] = v_bit;
        end
        w_qm[8] = ~w_use_xnor;
    end

    logic [8:0] r_qm;
    logic       r_de;
    logic [1:0] r_ctrl;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_qm   <= '0;
            r_de   <= 1'b0;
            r_ctrl <= 2'b00;
        end else begin
            r_qm   <= w_qm;
            r_de   <= i_de;
            r_ctrl <= i_ctrl;
        end
    end

    // ---------------- S2: symbol + disparity ----------------
    logic signed [4:0] r_cnt;
    logic signed [4:0] w_cnt_d;
    logic        [9:0] r_sym;
    logic        [9:0] w_sym;
    logic        [3:0] w_n1;
    logic        [3:0] w_n0;
    logic signed [5:0] w_n1_s;
    logic signed [5:0] w_n0_s;
    logic signed [5:0] w_cnt_x;
    logic signed [5:0] w_cnt_nx;

    always_comb begin
        w_n1     = 4'($countones(r_qm[7:0]));
        w_n0     = 4'd8 - w_n1;
        w_n1_s   = signed'({2'b00, w_n1});
        w_n0_s   = signed'({2'b00, w_n0});
        w_cnt_x  = {r_cnt[4], r_cnt};
        w_sym    = ctrl_token(r_ctrl);
        w_cnt_nx = '0;
        if (!r_de) begin
            // Blanking: control token, disparity restarts from zero.
            w_cnt_nx = '0;
        end else if ((r_cnt == 5'sd0) || (w_n1 == w_n0)) begin
            w_sym    = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
            w_cnt_nx = r_qm[8] ? (w_cnt_x + w_n1_s - w_n0_s) : (w_cnt_x + w_n0_s - w_n1_s);
        end else if (((r_cnt > 5'sd0) && (w_n1 > w_n0)) || ((r_cnt < 5'sd0) && (w_n0 > w_n1))) begin
            w_sym    = {1'b1, r_qm[8], ~r_qm[7:0]};
            w_cnt_nx = w_cnt_x + (r_qm[8] ? 6'sd2 : 6'sd0) + w_n0_s - w_n1_s;
        end else begin
            w_sym    = {1'b0, r_qm[8], r_qm[7:0]};
            w_cnt_nx = w_cnt_x + w_n1_s - w_n0_s - (r_qm[8] ? 6'sd0 : 6'sd2);
        end
        w_cnt_d = w_cnt_nx[4:0];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sym <= TOK_C00;
            r_cnt <= '0;
        end else begin
            r_sym <= w_sym;
            r_cnt <= w_cnt_d;
        end
    end

    // A balanced encoder never drifts beyond +/-10.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert ((w_cnt_nx >= -6'sd10) && (w_cnt_nx <= 6'sd10));
        end
    end

    assign o_sym = r_sym;

endmodule

// File: rtl/vga_tmds_enc.sv
// VGA (RGB444 + raw syncs) to three-channel TMDS encoder.
// Regenerates DE from sync assert edges, then encodes each colour channel.
// Fixed 3-clock latency: S0 input register, S1 q_m, S2 symbol.
// Ports:
//   clk        pixel clock
//   reset_n    synchronous active-low reset
//   VGA_HSYNC  horizontal sync, raw level
//   VGA_VSYNC  vertical sync, raw level
//   VGA_D      pixel, [11:8]=R [7:4]=G [3:0]=B
//   tmds_ch0   blue symbol, carries {VSYNC,HSYNC} in blanking
//   tmds_ch1   green symbol
//   tmds_ch2   red symbol
//   de_out     regenerated DE aligned with the symbols
module vga_tmds_enc
    import vga_tmds_enc_pkg::*;
#(
    parameter int unsigned H_START  = H_START_DEF,
    parameter int unsigned H_ACT    = H_ACT_DEF,
    parameter int unsigned V_START  = V_START_DEF,
    parameter int unsigned V_ACT    = V_ACT_DEF,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        VGA_HSYNC,
    input  logic        VGA_VSYNC,
    input  logic [11:0] VGA_D,
    output logic [9:0]  tmds_ch0,
    output logic [9:0]  tmds_ch1,
    output logic [9:0]  tmds_ch2,
    output logic        de_out
);

    localparam logic [10:0] H_LO      = 11'(H_START);
    localparam logic [10:0] H_HI      = 11'(H_START + H_ACT);
    localparam logic [9:0]  V_LO      = 10'(V_START);
    localparam logic [9:0]  V_HI      = 10'(V_START + V_ACT);
    localparam logic [10:0] HPOS_MAX  = 11'h7FF;
    localparam logic [9:0]  VLINE_MAX = 10'h3FF;

    // Sync history follows the pins even during reset, so an edge is only
    // ever a real transition seen on consecutive clocks.
    logic r_hs_prev;
    logic r_vs_prev;

    always_ff @(posedge clk) begin
        r_hs_prev <= VGA_HSYNC;
        r_vs_prev <= VGA_VSYNC;
    end

    logic w_hs_edge;
    logic w_vs_edge;

    assign w_hs_edge = (VGA_HSYNC == SYNC_POL) && (r_hs_prev != SYNC_POL);
    assign w_vs_edge = (VGA_VSYNC == SYNC_POL) && (r_vs_prev != SYNC_POL);

    logic [10:0] r_hpos;
    logic [10:0] w_hpos_d;
    logic [9:0]  r_vline;
    logic [9:0]  w_vline_d;
    logic        r_locked;
    logic        w_locked_d;
    logic        w_de;

    always_comb begin
        if (w_hs_edge) begin
            w_hpos_d = '0;
        end else if (r_hpos == HPOS_MAX) begin
            w_hpos_d = r_hpos;
        end else begin
            w_hpos_d = r_hpos + 11'd1;
        end

        w_vline_d = r_vline;
        if (w_vs_edge) begin
            w_vline_d = '0;
        end else if (w_hs_edge && (r_vline != VLINE_MAX)) begin
            w_vline_d = r_vline + 10'd1;
        end

        w_locked_d = r_locked | w_vs_edge;
        w_de = w_locked_d &&
               (w_hpos_d >= H_LO) && (w_hpos_d < H_HI) &&
               (w_vline_d >= V_LO) && (w_vline_d < V_HI);
    end

    // S0 plus DE delay line matching the two encoder stages.
    rgb444_t     r_pix;
    logic [1:0]  r_ctrl;
    logic        r_de;
    logic        r_de_p1;
    logic        r_de_p2;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hpos   <= '0;
            r_vline  <= '0;
            r_locked <= 1'b0;
            r_pix    <= '0;
            r_ctrl   <= 2'b00;
            r_de     <= 1'b0;
            r_de_p1  <= 1'b0;
            r_de_p2  <= 1'b0;
        end else begin
            r_hpos   <= w_hpos_d;
            r_vline  <= w_vline_d;
            r_locked <= w_locked_d;
            r_pix    <= VGA_D;
            r_ctrl   <= {VGA_VSYNC, VGA_HSYNC};
            r_de     <= w_de;
            r_de_p1  <= r_de;
            r_de_p2  <= r_de_p1;
        end
    end

    tmds_enc_ch u_ch0 (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_data  (expand4(r_pix.b)),
        .i_de    (r_de),
        .i_ctrl  (r_ctrl),
        .o_sym   (tmds_ch0)
    );

    tmds_enc_ch u_ch1 (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_data  (expand4(r_pix.g)),
        .i_de    (r_de),
        .i_ctrl  (2'b00),
        .o_sym   (tmds_ch1)
    );

    tmds_enc_ch u_ch2 (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_data  (expand4(r_pix.r)),
        .i_de    (r_de),
        .i_ctrl  (2'b00),
        .o_sym   (tmds_ch2)
    );

    assign de_out = r_de_p2;

endmodule

// File: tb/tb_vga_tmds_enc.sv
// Bench for vga_tmds_enc using a reduced video timing so whole frames are short.
module tb_vga_tmds_enc;

    localparam bit          POL  = 1'b0;
    localparam int unsigned HSW  = 4;
    localparam int unsigned H_ST = 10;
    localparam int unsigned H_AC = 20;
    localparam int unsigned HT   = 36;
    localparam int unsigned VSW  = 2;
    localparam int unsigned V_ST = 5;
    localparam int unsigned V_AC = 8;
    localparam int unsigned VT   = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        hs;
    logic        vs;
    logic [11:0] d;
    logic [9:0]  tmds_ch0;
    logic [9:0]  tmds_ch1;
    logic [9:0]  tmds_ch2;
    logic        de_out;

    vga_tmds_enc #(
        .H_START  (H_ST),
        .H_ACT    (H_AC),
        .V_START  (V_ST),
        .V_ACT    (V_AC),
        .SYNC_POL (POL)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .VGA_HSYNC (hs),
        .VGA_VSYNC (vs),
        .VGA_D     (d),
        .tmds_ch0  (tmds_ch0),
        .tmds_ch1  (tmds_ch1),
        .tmds_ch2  (tmds_ch2),
        .de_out    (de_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] c0;
        logic [9:0] c1;
        logic [9:0] c2;
        logic       de;
    } exp_t;

    localparam exp_t EXP_RST = '{c0: 10'h354, c1: 10'h354, c2: 10'h354, de: 1'b0};

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state.
    logic m_ph;
    logic m_pv;
    int   m_hpos;
    int   m_vline;
    bit   m_locked;
    int   m_cnt[3];

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] tok(input logic [1:0] c);
        case (c)
            2'd0:    return 10'h354;
            2'd1:    return 10'h0AB;
            2'd2:    return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    function automatic logic [9:0] enc(input int c, input logic [7:0] dat);
        int         ones;
        int         n1;
        int         n0;
        int         cnt;
        bit         xn;
        logic [8:0] qm;
        logic [9:0] s;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(dat[i]);
        xn = (ones > 4) || (ones == 4 && dat[0] == 1'b0);
        qm[0] = dat[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ dat[i]) : (qm[i-1] ^ dat[i]);
        qm[8] = !xn;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
        n0  = 8 - n1;
        cnt = m_cnt[c];
        if (cnt == 0 || n1 == n0) begin
            s = qm[8] ? {2'b01, qm[7:0]} : {2'b10, ~qm[7:0]};
            cnt += qm[8] ? (n1 - n0) : (n0 - n1);
        end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
            s = {1'b1, qm[8], ~qm[7:0]};
            cnt += 2 * int'(qm[8]) + n0 - n1;
        end else begin
            s = {1'b0, qm[8], qm[7:0]};
            cnt += n1 - n0 - (qm[8] ? 0 : 2);
        end
        m_cnt[c] = cnt;
        return s;
    endfunction

    task automatic compare(input exp_t p);
        chk("ch0", tmds_ch0, p.c0);
        chk("ch1", tmds_ch1, p.c1);
        chk("ch2", tmds_ch2, p.c2);
        chk("de", {9'b0, de_out}, {9'b0, p.de});
    endtask

    // One pixel clock: drive at the falling edge, then check the output that
    // belongs to the input driven three clocks earlier.
    task automatic step(input logic rst_n, input logic hs_i, input logic vs_i,
                        input logic [11:0] d_i);
        exp_t e;
        exp_t p;
        bit   he;
        bit   ve;
        @(negedge clk);
        reset_n = rst_n;
        hs      = hs_i;
        vs      = vs_i;
        d       = d_i;
        if (!rst_n) begin
            if (q.size() == 3) compare(q[0]);
            q = {EXP_RST, EXP_RST, EXP_RST};
            m_ph     = hs_i;
            m_pv     = vs_i;
            m_hpos   = 0;
            m_vline  = 0;
            m_locked = 0;
            m_cnt    = '{0, 0, 0};
        end else begin
            he = (hs_i == POL) && (m_ph != POL);
            ve = (vs_i == POL) && (m_pv != POL);
            m_hpos = he ? 0 : ((m_hpos < 2047) ? m_hpos + 1 : 2047);
            if (ve) m_vline = 0;
            else if (he && m_vline < 1023) m_vline++;
            if (ve) m_locked = 1;
            m_ph = hs_i;
            m_pv = vs_i;
            e.de = m_locked && m_hpos >= H_ST && m_hpos < H_ST + H_AC &&
                   m_vline >= V_ST && m_vline < V_ST + V_AC;
            if (e.de) begin
                e.c0 = enc(0, 8'(d_i[3:0] * 17));
                e.c1 = enc(1, 8'(d_i[7:4] * 17));
                e.c2 = enc(2, 8'(d_i[11:8] * 17));
            end else begin
                e.c0  = tok({vs_i, hs_i});
                e.c1  = 10'h354;
                e.c2  = 10'h354;
                m_cnt = '{0, 0, 0};
            end
            q.push_back(e);
            p = q.pop_front();
            compare(p);
        end
    endtask

    // mode 0: random pixels; 1: directed blue patterns; 3: reset mid-line;
    // 4: directed first pixel after re-lock.
    task automatic run_frame(input int first_line, input int mode, output int de_cnt);
        int          run;
        logic        pde;
        logic        rst;
        logic [11:0] px;
        logic        hs_v;
        logic        vs_v;
        de_cnt = 0;
        run    = 0;
        pde    = 1'b0;
        for (int ln = first_line; ln < int'(VT); ln++) begin
            for (int h = 0; h < int'(HT); h++) begin
                hs_v = (h < int'(HSW)) ? POL : ~POL;
                vs_v = (ln < int'(VSW)) ? POL : ~POL;
                px   = 12'($urandom);
                rst  = 1'b1;
                if (mode == 1 && ln == int'(V_ST) && h >= int'(H_ST) && h < int'(H_ST) + 3)
                    px[3:0] = 4'h0;
                if (mode == 1 && ln == int'(V_ST) + 1 && h == int'(H_ST)) px[3:0] = 4'hF;
                if (((mode == 1 && ln == int'(V_ST) + 2) || (mode == 4 && ln == int'(V_ST))) &&
                    h == int'(H_ST))
                    px[3:0] = 4'h0;
                if (mode == 3 && ln == int'(V_ST) + 1 &&
                    (h == int'(H_ST) + 5 || h == int'(H_ST) + 6))
                    rst = 1'b0;
                step(rst, hs_v, vs_v, px);
                if (mode == 1 && ln == int'(V_ST)) begin
                    if (h == int'(H_ST) + 2) chk("de_pre_rise", {9'b0, de_out}, 10'd0);
                    if (h == int'(H_ST) + 3) chk("de_rise", {9'b0, de_out}, 10'd1);
                    if (h == int'(H_ST) + 3) chk("blue0_a", tmds_ch0, 10'h100);
                    if (h == int'(H_ST) + 4) chk("blue0_b", tmds_ch0, 10'h3FF);
                    if (h == int'(H_ST) + 5) chk("blue0_c", tmds_ch0, 10'h100);
                end
                if (mode == 1 && ln == int'(V_ST) + 1 && h == int'(H_ST) + 3)
                    chk("blueF", tmds_ch0, 10'h200);
                if (mode == 1 && ln == int'(V_ST) + 2 && h == int'(H_ST) + 3)
                    chk("cnt_restart", tmds_ch0, 10'h100);
                if (mode == 4 && ln == int'(V_ST) && h == int'(H_ST) + 3)
                    chk("relock_first", tmds_ch0, 10'h100);
                if (de_out) begin
                    de_cnt++;
                    run++;
                end else begin
                    if (pde && mode != 3) chk("de_run", 10'(run), 10'(H_AC));
                    run = 0;
                end
                pde = de_out;
            end
        end
    endtask

    initial begin
        int dc;
        reset_n = 1'b0;
        hs      = 1'b1;
        vs      = 1'b1;
        d       = '0;

        // Reset, then three clocks of reset tokens after release.
        repeat (3) step(1'b0, 1'b1, 1'b1, 12'h000);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 12'($urandom));
            chk("rst_hold_ch0", tmds_ch0, 10'h354);
            chk("rst_hold_ch1", tmds_ch1, 10'h354);
            chk("rst_hold_ch2", tmds_ch2, 10'h354);
            chk("rst_hold_de", {9'b0, de_out}, 10'd0);
        end

        // Control tokens from raw sync levels.
        step(1'b1, 1'b0, 1'b1, 12'($urandom));
        chk("ctrl_11", tmds_ch0, 10'h2AB);
        step(1'b1, 1'b1, 1'b1, 12'($urandom));
        step(1'b1, 1'b1, 1'b1, 12'($urandom));
        step(1'b1, 1'b1, 1'b1, 12'($urandom));
        chk("ctrl_10", tmds_ch0, 10'h154);
        chk("ctrl_10_ch1", tmds_ch1, 10'h354);
        chk("ctrl_10_ch2", tmds_ch2, 10'h354);

        // Hsync activity without a vsync edge must never produce DE.
        run_frame(int'(VSW), 0, dc);
        chk("no_de_unlocked", 10'(dc), 10'd0);

        run_frame(0, 1, dc);
        chk("de_per_frame_a", 10'(dc), 10'(H_AC * V_AC));
        run_frame(0, 0, dc);
        chk("de_per_frame_b", 10'(dc), 10'(H_AC * V_AC));
        run_frame(0, 3, dc);
        run_frame(0, 4, dc);
        chk("de_per_frame_relock", 10'(dc), 10'(H_AC * V_AC));

        // Random syncs and pixels.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 499) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 29) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0,
                 12'($urandom));
        end
        repeat (4) step(1'b1, 1'b1, 1'b1, 12'($urandom));

        // Counter saturation: no hsync for >2047 clocks, then >1023 hsync edges.
        repeat (2100) step(1'b1, 1'b1, 1'b1, 12'($urandom));
        for (int i = 0; i < 2200; i++) begin
            step(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b1, 12'($urandom));
        end
        repeat (4) step(1'b1, 1'b1, 1'b1, 12'($urandom));

        run_frame(0, 0, dc);
        chk("de_per_frame_final", 10'(dc), 10'(H_AC * V_AC));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
